mips_multicycle_control: RTL and testbench

- Main control FSM plus ALU decoder that sequences the MIPS datapath through fetch, decode, execute, memory and writeback over several cycles.
- Drives the control inputs the datapath consumes: RegWrite, RegDst, ALUSrc, MemtoReg, Branch, Jump and ALU_Control.
- Waits on a shared instruction/data memory through a mem_req/mem_ready handshake.
- Sits between the instruction register, the datapath and the memory port.

---
 rtl/mips_multicycle_control_pkg.sv | 61 ++++++
 rtl/mips_multicycle_control_if.sv | 53 +++++
 rtl/mips_multicycle_control_alu_decoder.sv | 46 ++++
 rtl/mips_multicycle_control.sv | 197 +++++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 366 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS controller.
// Holds the controller state enum, the opcode and funct field values the
// controller recognises, the ALUOp request encoding passed to the ALU
// decoder and the ALU_Control encodings driven to the datapath ALU.
// No ports: imported by the interface, the ALU decoder and the top level.

package mips_pkg;

    // Controller states, one per datapath step of the instruction flow
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    // Operation requested of the ALU decoder by the main FSM
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    // Instr[31:26] values
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Instr[5:0] values for R-type instructions
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // ALU_Control encodings understood by the datapath ALU
    localparam logic [2:0] ALUC_ADD = 3'b010;
    localparam logic [2:0] ALUC_SUB = 3'b110;
    localparam logic [2:0] ALUC_AND = 3'b000;
    localparam logic [2:0] ALUC_OR  = 3'b001;
    localparam logic [2:0] ALUC_SLT = 3'b111;

    // True for the R-type funct codes the ALU can execute
    function automatic logic funct_supported(input logic [5:0] funct);
        return (funct == FUNCT_ADD) || (funct == FUNCT_SUB) ||
               (funct == FUNCT_AND) || (funct == FUNCT_OR)  ||
               (funct == FUNCT_SLT);
    endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the multicycle controller, the instruction
// register, the datapath and the shared memory port.
// Signals:
//   Op, Funct        instruction fields from the instruction register
//   zero             ALU zero flag from the datapath
//   mem_ready        memory completed the current access
//   mem_req, MemWrite, IorD          memory port request and address select
//   IRWrite, PCWrite, Branch, PCEn, PCSrc, Jump   PC / IR update controls
//   ALUSrcA, ALUSrcB, ALU_Control    ALU operand and operation selects
//   RegWrite, RegDst, MemtoReg       register file writeback controls
//   illegal          one-cycle pulse on an unsupported instruction
// Modports: master = controller side, slave = datapath/memory side.

interface mips_multicycle_control_if #(
    parameter int OPW   = 6,
    parameter int ALUCW = 3
);
    logic [OPW-1:0]   Op;
    logic [OPW-1:0]   Funct;
    logic             zero;
    logic             mem_ready;
    logic             mem_req;
    logic             MemWrite;
    logic             IorD;
    logic             IRWrite;
    logic             PCWrite;
    logic             Branch;
    logic             PCEn;
    logic [1:0]       PCSrc;
    logic             Jump;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [ALUCW-1:0] ALU_Control;
    logic             RegWrite;
    logic             RegDst;
    logic             MemtoReg;
    logic             illegal;

    modport master (
        input  Op, Funct, zero, mem_ready,
        output mem_req, MemWrite, IorD, IRWrite, PCWrite, Branch, PCEn,
               PCSrc, Jump, ALUSrcA, ALUSrcB, ALU_Control, RegWrite,
               RegDst, MemtoReg, illegal
    );

    modport slave (
        output Op, Funct, zero, mem_ready,
        input  mem_req, MemWrite, IorD, IRWrite, PCWrite, Branch, PCEn,
               PCSrc, Jump, ALUSrcA, ALUSrcB, ALU_Control, RegWrite,
               RegDst, MemtoReg, illegal
    );

endinterface

// File: rtl/mips_multicycle_control_alu_decoder.sv
// ALU decoder: turns the FSM's ALUOp request plus the instruction funct
// field into the ALU_Control code for the datapath ALU.
// Ports:
//   aluop          add / sub / use-funct request from the main FSM
//   funct          Instr[5:0]
//   alu_control    ALU operation select
//   funct_illegal  funct requested but not one the ALU supports

import mips_pkg::*;

module alu_decoder #(
    parameter int OPW   = 6,
    parameter int ALUCW = 3
) (
    input  aluop_t           aluop,
    input  logic [OPW-1:0]   funct,
    output logic [ALUCW-1:0] alu_control,
    output logic             funct_illegal
);

    // Unsupported funct codes still produce an add so the ALU sees a
    // defined operation; the flag lets the FSM abandon the instruction.
    always_comb begin
        alu_control   = ALUC_ADD;
        funct_illegal = 1'b0;
        case (aluop)
            ALUOP_ADD: alu_control = ALUC_ADD;
            ALUOP_SUB: alu_control = ALUC_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alu_control = ALUC_ADD;
                    FUNCT_SUB: alu_control = ALUC_SUB;
                    FUNCT_AND: alu_control = ALUC_AND;
                    FUNCT_OR:  alu_control = ALUC_OR;
                    FUNCT_SLT: alu_control = ALUC_SLT;
                    default: begin
                        alu_control   = ALUC_ADD;
                        funct_illegal = 1'b1;
                    end
                endcase
            end
            default: alu_control = ALUC_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main controller: sequences fetch, decode, execute,
// memory and writeback, and drives every datapath control through the
// master modport of mips_multicycle_control_if.
// Ports:
//   clk  system clock, all state changes on the rising edge
//   rst  synchronous active-high reset; forces all outputs low while high
//   bus  controller side of the control bundle (instruction fields in,
//        memory handshake and datapath controls out)
// Outputs are decoded from the state only, except PCEn (uses zero),
// IRWrite/PCWrite in FETCH (qualified by mem_ready), illegal in DECODE
// (uses Op) and ALU_Control in EXECUTE (uses Funct).

import mips_pkg::*;

module mips_multicycle_control #(
    parameter int OPW   = 6,
    parameter int ALUCW = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    mips_multicycle_control_if.master  bus
);

    state_t           state;
    state_t           next_state;
    aluop_t           aluop;
    logic [ALUCW-1:0] dec_alu_control;
    logic             funct_illegal;

    logic             mem_req;
    logic             mem_write;
    logic             iord;
    logic             ir_write;
    logic             pc_write;
    logic             branch;
    logic             jump;
    logic [1:0]       pcsrc;
    logic             alusrca;
    logic [1:0]       alusrcb;
    logic             alu_en;
    logic             reg_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             illegal;

    // ALUOp depends on state alone, kept outside the main decode so the
    // decoder's funct_illegal feedback never forms a combinational cycle.
    assign aluop = (state == EXECUTE) ? ALUOP_FUNCT :
                   (state == BRANCH)  ? ALUOP_SUB   : ALUOP_ADD;

    alu_decoder #(
        .OPW   (OPW),
        .ALUCW (ALUCW)
    ) u_alu_decoder (
        .aluop         (aluop),
        .funct         (bus.Funct),
        .alu_control   (dec_alu_control),
        .funct_illegal (funct_illegal)
    );

    // State register with synchronous reset back to instruction fetch
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and raw control decode. Everything defaults low so each
    // state only names the controls it actually asserts.
    always_comb begin
        next_state = FETCH;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        pcsrc      = 2'b00;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        alu_en     = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;

        case (state)
            // PC+4 is computed while the instruction is read; IR and PC
            // only load once the memory has actually returned the word.
            FETCH: begin
                mem_req    = 1'b1;
                alusrcb    = 2'b01;
                alu_en     = 1'b1;
                ir_write   = bus.mem_ready;
                pc_write   = bus.mem_ready;
                next_state = bus.mem_ready ? DECODE : FETCH;
            end
            // Branch target PC + (SignImm << 2) is prepared speculatively
            DECODE: begin
                alusrcb = 2'b11;
                alu_en  = 1'b1;
                case (bus.Op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = EXECUTE;
                    OP_BEQ:       next_state = BRANCH;
                    OP_ADDI:      next_state = ADDIEXEC;
                    OP_J:         next_state = JUMP;
                    default: begin
                        next_state = FETCH;
                        illegal    = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alu_en     = 1'b1;
                next_state = (bus.Op == OP_SW) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                mem_req    = 1'b1;
                iord       = 1'b1;
                next_state = bus.mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                next_state = FETCH;
            end
            MEMWRITE: begin
                mem_req    = 1'b1;
                iord       = 1'b1;
                mem_write  = 1'b1;
                next_state = bus.mem_ready ? FETCH : MEMWRITE;
            end
            // An unsupported funct abandons the instruction before writeback
            EXECUTE: begin
                alusrca    = 1'b1;
                alu_en     = 1'b1;
                illegal    = funct_illegal;
                next_state = funct_illegal ? FETCH : ALUWB;
            end
            ALUWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                next_state = FETCH;
            end
            BRANCH: begin
                alusrca    = 1'b1;
                alu_en     = 1'b1;
                branch     = 1'b1;
                pcsrc      = 2'b01;
                next_state = FETCH;
            end
            ADDIEXEC: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alu_en     = 1'b1;
                next_state = ADDIWB;
            end
            ADDIWB: begin
                reg_write  = 1'b1;
                next_state = FETCH;
            end
            JUMP: begin
                pc_write   = 1'b1;
                pcsrc      = 2'b10;
                jump       = 1'b1;
                next_state = FETCH;
            end
            default: next_state = FETCH;
        endcase
    end

    // Reset gates every output so no write or memory request escapes in
    // the reset cycle, even when reset lands in the middle of a wait.
    assign bus.mem_req     = mem_req    & ~rst;
    assign bus.MemWrite    = mem_write  & ~rst;
    assign bus.IorD        = iord       & ~rst;
    assign bus.IRWrite     = ir_write   & ~rst;
    assign bus.PCWrite     = pc_write   & ~rst;
    assign bus.Branch      = branch     & ~rst;
    assign bus.Jump        = jump       & ~rst;
    assign bus.ALUSrcA     = alusrca    & ~rst;
    assign bus.RegWrite    = reg_write  & ~rst;
    assign bus.RegDst      = reg_dst    & ~rst;
    assign bus.MemtoReg    = mem_to_reg & ~rst;
    assign bus.illegal     = illegal    & ~rst;
    assign bus.PCSrc       = rst ? 2'b00 : pcsrc;
    assign bus.ALUSrcB     = rst ? 2'b00 : alusrcb;
    assign bus.ALU_Control = (rst || !alu_en) ? '0 : dec_alu_control;
    assign bus.PCEn        = (pc_write | (branch & bus.zero)) & ~rst;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control. A memory responder
// answers requests after a programmable number of wait cycles; each
// instruction is observed as a summary record (cycle count, writebacks,
// memory transfers, PC updates, ALU operation) and compared with a
// record predicted from the instruction-level behaviour.

module tb_mips_multicycle_control;

   typedef struct packed {
      logic [7:0] cycles;
      logic [7:0] rw;
      logic       regdst;
      logic       m2r;
      logic [7:0] reads;
      logic [7:0] writes;
      logic [7:0] mwcyc;
      logic [7:0] pcw;
      logic [7:0] pcen;
      logic [7:0] br;
      logic [7:0] jmp;
      logic [7:0] ill;
      logic [2:0] aluc;
      logic [7:0] viol;
      logic       timeout;
   } obs_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   int   fw = 0;
   int   dw = 0;
   int   pend = 0;

   mips_multicycle_control_if bus ();

   mips_multicycle_control dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Memory responder: grants a request after fw (fetch) or dw (data)
   // idle cycles; toggles mem_ready randomly while nothing is requested.
   always @(negedge clk) begin
      if (bus.mem_req) begin
         if (pend >= (bus.IorD ? dw : fw)) begin
            bus.mem_ready = 1'b1;
            pend = 0;
         end else begin
            bus.mem_ready = 1'b0;
            pend++;
         end
      end else begin
         pend = 0;
         bus.mem_ready = ($urandom_range(0, 3) == 0);
      end
   end

   function automatic logic [19:0] outs();
      return {bus.mem_req, bus.MemWrite, bus.IorD, bus.IRWrite, bus.PCWrite,
              bus.Branch, bus.PCEn, bus.PCSrc, bus.Jump, bus.ALUSrcA,
              bus.ALUSrcB, bus.ALU_Control, bus.RegWrite, bus.RegDst,
              bus.MemtoReg, bus.illegal};
   endfunction

   // Expected per-instruction summary from the instruction semantics
   function automatic obs_t model(input logic [5:0] op, input logic [5:0] funct,
                                  input logic z, input int dwait);
      obs_t e;
      e      = '0;
      e.pcw  = 8'd1;
      e.pcen = 8'd1;
      case (op)
         6'b100011: begin
            e.cycles = 8'(5 + dwait); e.rw = 8'd1; e.m2r = 1'b1; e.reads = 8'd1;
         end
         6'b101011: begin
            e.cycles = 8'(4 + dwait); e.writes = 8'd1; e.mwcyc = 8'(dwait + 1);
         end
         6'b000000: begin
            e.cycles = 8'd4; e.rw = 8'd1; e.regdst = 1'b1;
            case (funct)
               6'b100000: e.aluc = 3'b010;
               6'b100010: e.aluc = 3'b110;
               6'b100100: e.aluc = 3'b000;
               6'b100101: e.aluc = 3'b001;
               6'b101010: e.aluc = 3'b111;
               default: begin
                  e.cycles = 8'd3; e.rw = 8'd0; e.regdst = 1'b0;
                  e.ill = 8'd1; e.aluc = 3'b010;
               end
            endcase
         end
         6'b000100: begin
            e.cycles = 8'd3; e.br = 8'd1; e.aluc = 3'b110;
            e.pcen = 8'(1 + int'(z));
         end
         6'b001000: begin
            e.cycles = 8'd4; e.rw = 8'd1;
         end
         6'b000010: begin
            e.cycles = 8'd3; e.jmp = 8'd1; e.pcw = 8'd2; e.pcen = 8'd2;
         end
         default: begin
            e.cycles = 8'd2; e.ill = 8'd1;
         end
      endcase
      return e;
   endfunction

   // Accumulates one sampled cycle into the observation record
   task automatic sample_cycle(inout obs_t o);
      int n;
      if (bus.RegWrite) begin
         o.rw = o.rw + 8'd1; o.regdst = bus.RegDst; o.m2r = bus.MemtoReg;
      end
      if (bus.mem_req && bus.IorD && bus.MemWrite) o.mwcyc = o.mwcyc + 8'd1;
      if (bus.mem_req && bus.IorD && bus.mem_ready) begin
         if (bus.MemWrite) o.writes = o.writes + 8'd1;
         else              o.reads  = o.reads + 8'd1;
      end
      if (bus.PCWrite) o.pcw  = o.pcw + 8'd1;
      if (bus.PCEn)    o.pcen = o.pcen + 8'd1;
      if (bus.Branch)  o.br   = o.br + 8'd1;
      if (bus.Jump)    o.jmp  = o.jmp + 8'd1;
      if (bus.illegal) o.ill  = o.ill + 8'd1;
      if (bus.ALUSrcA && bus.ALUSrcB == 2'b00) o.aluc = bus.ALU_Control;
      n = int'(bus.RegWrite) + int'(bus.MemWrite) + int'(bus.PCWrite) + int'(bus.IRWrite);
      if (n > 1 && !(n == 2 && bus.IRWrite && bus.PCWrite)) o.viol = o.viol + 8'd1;
      if (bus.Jump != (bus.PCSrc == 2'b10)) o.viol = o.viol + 8'd1;
   endtask

   // Runs one instruction from the current fetch cycle to the next fetch
   task automatic run_instr(input logic [5:0] op, input logic [5:0] funct,
                            input logic z, input int fwait, input int dwait,
                            output obs_t o);
      int n;
      o = '0;
      bus.Op = op; bus.Funct = funct; bus.zero = z;
      fw = fwait; dw = dwait;
      n = 0;
      while (!bus.IRWrite && n < 30) begin
         @(negedge clk); #1; n++;
      end
      if (!bus.IRWrite) begin
         o.timeout = 1'b1;
         return;
      end
      o.cycles = 8'd1;
      sample_cycle(o);
      n = 0;
      forever begin
         @(negedge clk); #1;
         if (bus.mem_req && !bus.IorD) break;
         n++;
         if (n > 40) begin
            o.timeout = 1'b1;
            break;
         end
         o.cycles = o.cycles + 8'd1;
         sample_cycle(o);
      end
   endtask

   // Holds reset and checks every output stays low, then checks the
   // first FETCH after release
   task automatic test_reset();
      rst = 1'b1;
      bus.Op = 6'b111111; bus.Funct = 6'd0; bus.zero = 1'b1;
      repeat (3) begin
         @(negedge clk); #1;
         checks++;
         if (outs() !== 20'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h expected 0", outs());
         end
      end
      rst = 1'b0; #1;
      checks++;
      if ({bus.mem_req, bus.IorD, bus.ALUSrcB, bus.ALU_Control} !== 7'b10_01_010) begin
         errors++;
         $display("[TB] FAIL reset_release_fetch: got %b expected 1001010",
                  {bus.mem_req, bus.IorD, bus.ALUSrcB, bus.ALU_Control});
      end
   endtask

   // Load word with no memory wait
   task automatic test_lw();
      obs_t o, e;
      run_instr(6'b100011, 6'd0, 1'b0, 0, 0, o);
      e = model(6'b100011, 6'd0, 1'b0, 0);
      checks++;
      if (o.cycles !== 8'd5) begin
         errors++;
         $display("[TB] FAIL lw_cycles: got %0d expected 5", o.cycles);
      end
      checks++;
      if (o !== e) begin
         errors++;
         $display("[TB] FAIL lw_record: got %h expected %h", o, e);
      end
   endtask

   // R-type subtract through EXECUTE and ALUWB
   task automatic test_rtype_sub();
      obs_t o, e;
      run_instr(6'b000000, 6'b100010, 1'b0, 1, 0, o);
      e = model(6'b000000, 6'b100010, 1'b0, 0);
      checks++;
      if (o.aluc !== 3'b110) begin
         errors++;
         $display("[TB] FAIL rtype_sub_aluc: got %b expected 110", o.aluc);
      end
      checks++;
      if (o !== e) begin
         errors++;
         $display("[TB] FAIL rtype_sub_record: got %h expected %h", o, e);
      end
   endtask

   // Branch taken and not taken
   task automatic test_beq();
      obs_t o, e;
      for (int z = 1; z >= 0; z--) begin
         run_instr(6'b000100, 6'd0, 1'(z), 0, 0, o);
         e = model(6'b000100, 6'd0, 1'(z), 0);
         checks++;
         if (o.cycles !== 8'd3 || o.pcen !== 8'(1 + z)) begin
            errors++;
            $display("[TB] FAIL beq_zero%0d_pcen: got cycles=%0d pcen=%0d expected cycles=3 pcen=%0d",
                     z, o.cycles, o.pcen, 1 + z);
         end
         checks++;
         if (o !== e) begin
            errors++;
            $display("[TB] FAIL beq_zero%0d_record: got %h expected %h", z, o, e);
         end
      end
   endtask

   // Store word with a three-cycle memory wait
   task automatic test_sw_wait();
      obs_t o, e;
      run_instr(6'b101011, 6'd0, 1'b0, 2, 3, o);
      e = model(6'b101011, 6'd0, 1'b0, 3);
      checks++;
      if (o.mwcyc !== 8'd4 || o.cycles !== 8'd7) begin
         errors++;
         $display("[TB] FAIL sw_wait_hold: got hold=%0d cycles=%0d expected hold=4 cycles=7",
                  o.mwcyc, o.cycles);
      end
      checks++;
      if (o !== e) begin
         errors++;
         $display("[TB] FAIL sw_wait_record: got %h expected %h", o, e);
      end
   endtask

   // Unsupported opcode pulses illegal and returns to FETCH
   task automatic test_illegal_op();
      obs_t o, e;
      run_instr(6'b111111, 6'd0, 1'b0, 0, 0, o);
      e = model(6'b111111, 6'd0, 1'b0, 0);
      checks++;
      if (o.ill !== 8'd1 || o.rw !== 8'd0 || o.mwcyc !== 8'd0 || o.cycles !== 8'd2) begin
         errors++;
         $display("[TB] FAIL illegal_op: got ill=%0d rw=%0d mw=%0d cycles=%0d expected 1 0 0 2",
                  o.ill, o.rw, o.mwcyc, o.cycles);
      end
      checks++;
      if (o !== e) begin
         errors++;
         $display("[TB] FAIL illegal_op_record: got %h expected %h", o, e);
      end
   endtask

   // Reset asserted while MEMREAD is waiting on memory
   task automatic test_reset_in_memread();
      obs_t o, e;
      int n;
      bus.Op = 6'b100011; bus.Funct = 6'd0; fw = 0; dw = 20;
      n = 0;
      while (!(bus.mem_req && bus.IorD) && n < 40) begin
         @(negedge clk); #1; n++;
      end
      checks++;
      if (!(bus.mem_req && bus.IorD)) begin
         errors++;
         $display("[TB] FAIL reach_memread: got mem_req=%b IorD=%b expected 1 1",
                  bus.mem_req, bus.IorD);
      end
      @(negedge clk); #1;
      rst = 1'b1; #1;
      checks++;
      if (outs() !== 20'd0) begin
         errors++;
         $display("[TB] FAIL reset_in_wait: got %h expected 0", outs());
      end
      @(negedge clk); #1;
      checks++;
      if (outs() !== 20'd0) begin
         errors++;
         $display("[TB] FAIL reset_held_fetch: got %h expected 0", outs());
      end
      rst = 1'b0; dw = 0; #1;
      checks++;
      if ({bus.mem_req, bus.IorD} !== 2'b10) begin
         errors++;
         $display("[TB] FAIL reset_mid_release: got %b expected 10", {bus.mem_req, bus.IorD});
      end
      run_instr(6'b100011, 6'd0, 1'b0, 0, 1, o);
      e = model(6'b100011, 6'd0, 1'b0, 1);
      checks++;
      if (o !== e) begin
         errors++;
         $display("[TB] FAIL lw_after_reset: got %h expected %h", o, e);
      end
   endtask

   // Random instruction mix with random memory waits
   task automatic test_random();
      logic [5:0] ops [7];
      logic [5:0] functs [5];
      logic [5:0] op, funct;
      logic       z;
      int         fwait, dwait;
      obs_t       o, e;
      ops    = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b000000};
      functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      for (int i = 0; i < 40; i++) begin
         op = ops[$urandom_range(0, 6)];
         if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(0, 63));
         funct = functs[$urandom_range(0, 4)];
         if ($urandom_range(0, 4) == 0) funct = 6'($urandom_range(0, 63));
         z     = 1'($urandom_range(0, 1));
         fwait = $urandom_range(0, 3);
         dwait = $urandom_range(0, 3);
         run_instr(op, funct, z, fwait, dwait, o);
         e = model(op, funct, z, dwait);
         checks++;
         if (o !== e) begin
            errors++;
            $display("[TB] FAIL random_%0d op=%b funct=%b: got %h expected %h",
                     i, op, funct, o, e);
         end
      end
   endtask

   // Test sequence and final summary
   initial begin
      test_reset();
      test_lw();
      test_rtype_sub();
      test_beq();
      test_sw_wait();
      test_illegal_op();
      test_reset_in_memread();
      test_random();
      $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
